// File: rtl/jt51_opacc_if.sv
// Port bundle for the FM operator output accumulator: slot markers, operator data,
// channel routing in; exact and DAC-style stereo outputs back.
interface jt51_opacc_if;
    logic               cen;
    logic               m1_enters;
    logic               m2_enters;
    logic               c1_enters;
    logic               c2_enters;
    logic               op31_acc;
    logic [1:0]         rl_I;
    logic [2:0]         con_I;
    logic signed [13:0] op_out;
    logic               ne;
    logic signed [10:0] noise;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic signed [15:0] xleft;
    logic signed [15:0] xright;

    modport master (
        output cen, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
        output rl_I, con_I, op_out, ne, noise,
        input  left, right, xleft, xright
    );

    modport slave (
        input  cen, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
        input  rl_I, con_I, op_out, ne, noise,
        output left, right, xleft, xright
    );
endinterface

// File: rtl/jt51_opacc.sv
// FM operator output accumulator: per-channel carrier sums in an 8-slot circulating
// delay line, stereo mixing, per-sample latching and a 10+3 floating-point DAC view.
module jt51_opacc (
    input logic         clk,
    input logic         rst,
    jt51_opacc_if.slave bus
);

    logic [7:0][15:0] dly_q;
    logic [15:0]      total;
    logic [13:0]      op_val;
    logic [15:0]      op_ext;
    logic [16:0]      sum17;
    logic [15:0]      opsum;
    logic             sum_en;
    logic             sum_all_q;
    logic [15:0]      pre_left_q, pre_right_q;
    logic [15:0]      xleft_q, xright_q;
    logic [15:0]      gated_l, gated_r;
    logic [12:0]      cmp_l, cmp_r;

    assign total = dly_q[7];

    // Noise replaces operator 31 output, scaled by two to match operator range
    always_comb begin
        op_val = bus.op_out;
        if (bus.ne && bus.op31_acc) begin
            op_val = {bus.noise[10], bus.noise[10], bus.noise, 1'b0};
        end
    end

    assign op_ext = {{2{op_val[13]}}, op_val};

    // Carrier selection per connection algorithm
    always_comb begin
        sum_en = 1'b0;
        case (bus.con_I)
            3'd0, 3'd1, 3'd2, 3'd3: sum_en = bus.m2_enters;
            3'd4:                   sum_en = bus.m1_enters | bus.m2_enters;
            3'd5, 3'd6:             sum_en = ~bus.c1_enters;
            default:                sum_en = 1'b1;
        endcase
    end

    always_comb begin
        sum17 = {op_ext[15], op_ext} + {total[15], total};
        opsum = total;
        if (bus.c2_enters) begin
            // C2 opens a fresh channel sum
            opsum = sum_en ? op_ext : 16'h0000;
        end else if (sum_en) begin
            if (sum17[16] != sum17[15]) begin
                opsum = sum17[16] ? 16'h8000 : 16'h7fff;
            end else begin
                opsum = sum17[15:0];
            end
        end
    end

    assign gated_l = bus.rl_I[0] ? total : 16'h0000;
    assign gated_r = bus.rl_I[1] ? total : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly_q       <= '0;
            sum_all_q   <= 1'b0;
            pre_left_q  <= 16'h0000;
            pre_right_q <= 16'h0000;
            xleft_q     <= 16'h0000;
            xright_q    <= 16'h0000;
        end else if (bus.cen) begin
            dly_q <= {dly_q[6:0], opsum};
            if (bus.c2_enters) begin
                sum_all_q <= 1'b1;
                // Channel mix wraps; saturation only happens inside a channel
                if (!sum_all_q) begin
                    pre_left_q  <= gated_l;
                    pre_right_q <= gated_r;
                end else begin
                    pre_left_q  <= pre_left_q + gated_l;
                    pre_right_q <= pre_right_q + gated_r;
                end
            end
            // Placed after the c2 update so the sample-boundary clear wins
            if (bus.c1_enters) begin
                sum_all_q <= 1'b0;
                xleft_q   <= pre_left_q;
                xright_q  <= pre_right_q;
            end
        end
    end

    // Returns {exp[2:0], man[9:0]} from the run of leading sign copies
    function automatic logic [12:0] compress(input logic [15:0] lin);
        logic s;
        s = lin[15];
        if (lin[14] != s) return {3'd7, lin[15:6]};
        if (lin[13] != s) return {3'd6, lin[14:5]};
        if (lin[12] != s) return {3'd5, lin[13:4]};
        if (lin[11] != s) return {3'd4, lin[12:3]};
        if (lin[10] != s) return {3'd3, lin[11:2]};
        if (lin[9] != s)  return {3'd2, lin[10:1]};
        return {3'd1, lin[9:0]};
    endfunction

    function automatic logic [15:0] expand(input logic [2:0] e, input logic [9:0] man);
        logic [15:0] ext;
        ext = {{6{man[9]}}, man};
        if (e == 3'd0) return 16'h0000;
        return ext << (e - 3'd1);
    endfunction

    assign cmp_l = compress(xleft_q);
    assign cmp_r = compress(xright_q);

    assign bus.xleft  = xleft_q;
    assign bus.xright = xright_q;
    assign bus.left   = expand(cmp_l[12:10], cmp_l[9:0]);
    assign bus.right  = expand(cmp_r[12:10], cmp_r[9:0]);

endmodule

// File: tb/tb_jt51_opacc.sv
// Directed bench for jt51_opacc: builds channel sums slot by slot and checks the
// latched exact and DAC-style outputs against hand-computed values.
module tb_jt51_opacc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total_n = 0;
    int   bad_n = 0;

    always #5 clk = ~clk;

    jt51_opacc_if bus ();

    jt51_opacc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One cen cycle; markers return low afterwards
    task automatic step(input logic c2, input logic c1, input logic m1, input logic m2,
                        input logic [2:0] con, input logic [13:0] op, input logic [1:0] rl);
        bus.cen       = 1'b1;
        bus.c2_enters = c2;
        bus.c1_enters = c1;
        bus.m1_enters = m1;
        bus.m2_enters = m2;
        bus.con_I     = con;
        bus.op_out    = op;
        bus.rl_I      = rl;
        @(posedge clk);
        #1;
        bus.cen       = 1'b0;
        bus.c2_enters = 1'b0;
        bus.c1_enters = 1'b0;
        bus.m1_enters = 1'b0;
        bus.m2_enters = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Slot 0 gets a0 plus nadds recirculated adds, then is mixed and latched
    task automatic build_slot0(input logic [13:0] a0, input logic [13:0] add,
                               input int nadds, input logic [1:0] rl);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, a0, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        idle(6);
        for (int k = 0; k < nadds; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, add, 2'b00);
            idle(7);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, rl);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
    endtask

    task automatic test_reset();
        total_n++; if (bus.xleft !== 16'h0000) begin bad_n++; $display("FAIL rst_xleft got=%h want=0000", bus.xleft); end
        total_n++; if (bus.xright !== 16'h0000) begin bad_n++; $display("FAIL rst_xright got=%h want=0000", bus.xright); end
        total_n++; if (bus.left !== 16'h0000) begin bad_n++; $display("FAIL rst_left got=%h want=0000", bus.left); end
        total_n++; if (bus.right !== 16'h0000) begin bad_n++; $display("FAIL rst_right got=%h want=0000", bus.right); end
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 14'd500, 2'b00);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        total_n++; if (bus.xleft !== 16'd4000) begin bad_n++; $display("FAIL pre_rst_sum got=%h want=%h", bus.xleft, 16'd4000); end
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 14'd500, 2'b00);
        bus.cen = 1'b1;
        rst = 1'b0;
        #2;
        total_n++; if (bus.xleft !== 16'h0000) begin bad_n++; $display("FAIL mid_rst_xleft got=%h want=0000", bus.xleft); end
        total_n++; if (bus.xright !== 16'h0000) begin bad_n++; $display("FAIL mid_rst_xright got=%h want=0000", bus.xright); end
        total_n++; if (bus.left !== 16'h0000) begin bad_n++; $display("FAIL mid_rst_left got=%h want=0000", bus.left); end
        total_n++; if (bus.right !== 16'h0000) begin bad_n++; $display("FAIL mid_rst_right got=%h want=0000", bus.right); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.cen = 1'b0;
        // Any slot surviving the reset would show up in this eight-slot mix
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        total_n++; if (bus.xleft !== 16'h0000) begin bad_n++; $display("FAIL post_rst_dly_l got=%h want=0000", bus.xleft); end
        total_n++; if (bus.xright !== 16'h0000) begin bad_n++; $display("FAIL post_rst_dly_r got=%h want=0000", bus.xright); end
    endtask

    task automatic test_compress();
        logic [13:0] a0s   [5] = '{14'h1234, 14'h0155, 14'h2001, 14'h3fff, 14'h1fff};
        logic [13:0] adds  [5] = '{14'h0000, 14'h0000, 14'h2000, 14'h0000, 14'h1fff};
        int          nadd  [5] = '{0, 0, 3, 0, 5};
        logic [15:0] want_x[5] = '{16'h1234, 16'h0155, 16'h8001, 16'hffff, 16'h7fff};
        logic [15:0] want_l[5] = '{16'h1230, 16'h0155, 16'h8000, 16'hffff, 16'h7fc0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            build_slot0(a0s[i], adds[i], nadd[i], 2'b11);
            total_n++; if (bus.xleft !== want_x[i]) begin bad_n++; $display("FAIL cmp_xleft[%0d] got=%h want=%h", i, bus.xleft, want_x[i]); end
            total_n++; if (bus.left !== want_l[i]) begin bad_n++; $display("FAIL cmp_left[%0d] got=%h want=%h", i, bus.left, want_l[i]); end
            total_n++; if (bus.right !== want_l[i]) begin bad_n++; $display("FAIL cmp_right[%0d] got=%h want=%h", i, bus.right, want_l[i]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        build_slot0(14'h2000, 14'h2000, 5, 2'b11);
        total_n++; if (bus.xleft !== 16'h8000) begin bad_n++; $display("FAIL sat_neg_xleft got=%h want=8000", bus.xleft); end
        total_n++; if (bus.xright !== 16'h8000) begin bad_n++; $display("FAIL sat_neg_xright got=%h want=8000", bus.xright); end
        total_n++; if (bus.left !== 16'h8000) begin bad_n++; $display("FAIL sat_neg_left got=%h want=8000", bus.left); end
    endtask

    task automatic test_gating();
        logic [1:0]  rls    [2] = '{2'b11, 2'b01};
        logic [2:0]  m1_con [2] = '{3'd0, 3'd4};
        logic [15:0] want_l [2] = '{16'd100, 16'd150};
        logic [15:0] want_r [2] = '{16'd100, 16'd0};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd500, 2'b00);
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
            idle(6);
            step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 14'd100, 2'b00);
            idle(7);
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 14'd777, 2'b00);
            idle(7);
            // M1 counts only under algorithm 4
            step(1'b0, 1'b0, 1'b1, 1'b0, m1_con[i], 14'd50, 2'b00);
            idle(7);
            step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, rls[i]);
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
            total_n++; if (bus.xleft !== want_l[i]) begin bad_n++; $display("FAIL gate_xleft[%0d] got=%h want=%h", i, bus.xleft, want_l[i]); end
            total_n++; if (bus.xright !== want_r[i]) begin bad_n++; $display("FAIL gate_xright[%0d] got=%h want=%h", i, bus.xright, want_r[i]); end
        end
        bus.cen = 1'b0;
        bus.c2_enters = 1'b1;
        bus.rl_I = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        bus.c2_enters = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        total_n++; if (bus.xleft !== 16'd150) begin bad_n++; $display("FAIL cen_hold got=%h want=%h", bus.xleft, 16'd150); end
    endtask

    task automatic test_noise();
        do_reset();
        bus.ne = 1'b1;
        bus.op31_acc = 1'b1;
        bus.noise = 11'h7fd;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 14'h1234, 2'b00);
        bus.ne = 1'b0;
        bus.op31_acc = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        total_n++; if (bus.xleft !== 16'hfffa) begin bad_n++; $display("FAIL noise_xleft got=%h want=fffa", bus.xleft); end
        total_n++; if (bus.left !== 16'hfffa) begin bad_n++; $display("FAIL noise_left got=%h want=fffa", bus.left); end
        total_n++; if (bus.right !== 16'hfffa) begin bad_n++; $display("FAIL noise_right got=%h want=fffa", bus.right); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 14'd6144, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 14'd6144, 2'b00);
        idle(5);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 14'd6144, 2'b00);
            idle(1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 14'd6144, 2'b00);
            idle(5);
        end
        // Slots 0 and 2 each hold 0x6000; their sum wraps at the mix
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, 2'b11);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0, 2'b00);
        total_n++; if (bus.xleft !== 16'hc000) begin bad_n++; $display("FAIL wrap_xleft got=%h want=c000", bus.xleft); end
        total_n++; if (bus.xright !== 16'hc000) begin bad_n++; $display("FAIL wrap_xright got=%h want=c000", bus.xright); end
        total_n++; if (bus.left !== 16'hc000) begin bad_n++; $display("FAIL wrap_left got=%h want=c000", bus.left); end
    endtask

    initial begin
        bus.cen       = 1'b0;
        bus.m1_enters = 1'b0;
        bus.m2_enters = 1'b0;
        bus.c1_enters = 1'b0;
        bus.c2_enters = 1'b0;
        bus.op31_acc  = 1'b0;
        bus.rl_I      = 2'b00;
        bus.con_I     = 3'd0;
        bus.op_out    = 14'd0;
        bus.ne        = 1'b0;
        bus.noise     = 11'd0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_compress();
        test_saturation();
        test_gating();
        test_noise();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
